sram_port0_arbiter: RTL and testbench

//  Shares RW port 0 of the 1rw1r 32x256 SRAM macro between two requesters: req 0 = core LSU, req 1 = debug/loader.

---
 rtl/sram_arb_pkg.sv | 40 ++++
 rtl/rr_arb2.sv | 54 +++++
 rtl/sram_port0_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_sram_port0_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
//   Shared types and constants for the SRAM port-0 arbiter.
//   - Requester ids (LSU = 0, debug/loader = 1).
//   - Default macro geometry (32-bit words, 256 entries, 4 byte lanes).
//   - sram_req_t   : one requester's command as presented to the macro mux.
//   - rsp_pipe_t   : the one-deep response pipeline entry.
//   - state_t      : arbiter top-level FSM states.
// -----------------------------------------------------------------------------
package sram_arb_pkg;

  // Requester ids; also the bit position in the per-requester vectors.
  localparam logic REQ_LSU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  // Default macro geometry (sky130 1rw1r 32x256).
  localparam int SRAM_AW = 8;
  localparam int SRAM_DW = 32;
  localparam int SRAM_NM = SRAM_DW / 8;

  typedef struct packed {
    logic               we;
    logic [SRAM_NM-1:0] be;
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] wdata;
  } sram_req_t;

  // What the response stage needs to remember about the accepted request.
  typedef struct packed {
    logic valid;
    logic id;
    logic we;
  } rsp_pipe_t;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage : sram_arb_pkg

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin arbiter with a one-bit priority register.
//   At most one grant per cycle. With a single valid requester it wins
//   outright; with both valid, the requester that did not win last time wins.
//   After reset requester 0 (LSU) is preferred.
//
// Ports
//   clk       in   1  clock
//   rst_n     in   1  asynchronous active-low reset
//   en        in   1  arbitration enable; no grants while low
//   valid     in   2  per-requester request valid
//   grant     out  2  one-hot (or zero) grant, combinational from valid/en
//   grant_id  out  1  index of the granted requester (meaningful when |grant)
// -----------------------------------------------------------------------------
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       grant_id
);

  // prio_q names the requester that wins the next tie. Holding the preferred
  // id (rather than the last winner) lets the reset value 0 favour the LSU.
  logic prio_q;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (prio_q == REQ_DBG) ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign grant_id = grant[1];

  // Every grant hands the next tie to the other requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= REQ_LSU;
    end else if (|grant) begin
      prio_q <= ~grant_id;
    end
  end

endmodule : rr_arb2

// File: rtl/sram_port0_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port0_arbiter
//   Shares the RW port (port 0) of a 1rw1r SRAM macro between the core LSU
//   (requester 0) and the debug/loader (requester 1). Round-robin arbitration,
//   fixed one-cycle response latency, optional zero-fill after reset.
//
// Handshake: a request transfers in a cycle where req_valid_i[i] and
//   req_ready_o[i] are both high. A requester must hold valid and its command
//   stable until it sees ready; ready never depends on anything but the valids
//   and internal state. Every transfer produces exactly one rsp_valid_o[i]
//   pulse in the following cycle; there is no response backpressure.
//
// Ports
//   clk_i          in   1            clock, also the macro's clk0
//   rst_ni         in   1            asynchronous active-low reset
//   req_valid_i    in   2            per-requester request valid
//   req_ready_o    out  2            per-requester accept (== grant)
//   req_we_i       in   2            1 = write, 0 = read
//   req_be_i       in   2*NUM_WMASKS byte enables, requester i in slice i
//   req_addr_i     in   2*ADDR_WIDTH word address, requester i in slice i
//   req_wdata_i    in   2*DATA_WIDTH write data, requester i in slice i
//   rsp_valid_o    out  2            one-cycle response pulse to requester
//   rsp_rdata_o    out  DATA_WIDTH   read data; 0 for write acks / idle
//   init_done_o    out  1            high once zero-fill has finished
//   sram_csb_o     out  1            csb0 (active low)
//   sram_web_o     out  1            web0 (active low)
//   sram_wmask_o   out  NUM_WMASKS   wmask0
//   sram_addr_o    out  ADDR_WIDTH   addr0
//   sram_din_o     out  DATA_WIDTH   din0
//   sram_dout_i    in   DATA_WIDTH   dout0
// -----------------------------------------------------------------------------
module sram_port0_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_AW,
  parameter int DATA_WIDTH = SRAM_DW,
  parameter int NUM_WMASKS = SRAM_NM,
  parameter bit INIT_ZERO  = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [1:0]              req_valid_i,
  output logic [1:0]              req_ready_o,
  input  logic [1:0]              req_we_i,
  input  logic [2*NUM_WMASKS-1:0] req_be_i,
  input  logic [2*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [2*DATA_WIDTH-1:0] req_wdata_i,
  output logic [1:0]              rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    init_done_o,
  output logic                    sram_csb_o,
  output logic                    sram_web_o,
  output logic [NUM_WMASKS-1:0]   sram_wmask_o,
  output logic [ADDR_WIDTH-1:0]   sram_addr_o,
  output logic [DATA_WIDTH-1:0]   sram_din_o,
  input  logic [DATA_WIDTH-1:0]   sram_dout_i
);

  localparam int                    RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  // ---------------------------------------------------------------------------
  // FSM: INIT walks the whole array writing zeros, then RUN forever.
  // ---------------------------------------------------------------------------
  state_t                state_q;
  logic [ADDR_WIDTH-1:0] init_cnt_q;
  logic                  init_done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= INIT_ZERO ? ST_INIT : ST_RUN;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          // The last word is written on this edge, so RUN starts next cycle.
          if (init_cnt_q == LAST_ADDR) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          init_done_q <= 1'b1;
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign init_done_o = init_done_q;

  // ---------------------------------------------------------------------------
  // Arbitration. Gating with rst_ni keeps ready low while reset is held even
  // when the reset state is already RUN (INIT_ZERO = 0).
  // ---------------------------------------------------------------------------
  logic       arb_en;
  logic [1:0] grant;
  logic       grant_id;

  assign arb_en = rst_ni && (state_q == ST_RUN);

  rr_arb2 u_rr_arb2 (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .en       (arb_en),
    .valid    (req_valid_i),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready_o = grant;

  // ---------------------------------------------------------------------------
  // Selected request (command of the granted requester).
  // ---------------------------------------------------------------------------
  sram_req_t sel;

  always_comb begin
    sel       = '0;
    sel.we    = req_we_i[grant_id];
    sel.be    = grant_id ? req_be_i[2*NUM_WMASKS-1:NUM_WMASKS]
                         : req_be_i[NUM_WMASKS-1:0];
    sel.addr  = grant_id ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH]
                         : req_addr_i[ADDR_WIDTH-1:0];
    sel.wdata = grant_id ? req_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH]
                         : req_wdata_i[DATA_WIDTH-1:0];
  end

  // ---------------------------------------------------------------------------
  // Macro drive. Idle is csb=1/web=1 with everything else zero. The INIT
  // branch is gated with rst_ni so the macro is deselected the moment reset
  // asserts instead of seeing a write to address 0 while reset is held.
  // ---------------------------------------------------------------------------
  always_comb begin
    sram_csb_o   = 1'b1;
    sram_web_o   = 1'b1;
    sram_wmask_o = '0;
    sram_addr_o  = '0;
    sram_din_o   = '0;
    if (rst_ni && (state_q == ST_INIT)) begin
      sram_csb_o   = 1'b0;
      sram_web_o   = 1'b0;
      sram_wmask_o = '1;
      sram_addr_o  = init_cnt_q;
    end else if (|grant) begin
      sram_csb_o   = 1'b0;
      sram_web_o   = ~sel.we;
      sram_wmask_o = sel.we ? sel.be : '0;
      sram_addr_o  = sel.addr;
      sram_din_o   = sel.wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipeline. The macro captures the command at the accept edge and
  // drives dout at the following negedge, so the data is on sram_dout_i for
  // the second half of the response cycle.
  // ---------------------------------------------------------------------------
  rsp_pipe_t rsp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_q <= '0;
    end else begin
      rsp_q.valid <= |grant;
      rsp_q.id    <= grant_id;
      rsp_q.we    <= sel.we;
    end
  end

  always_comb begin
    rsp_valid_o = 2'b00;
    rsp_rdata_o = '0;
    if (rsp_q.valid) begin
      rsp_valid_o = (rsp_q.id == REQ_DBG) ? 2'b10 : 2'b01;
      if (!rsp_q.we) begin
        rsp_rdata_o = sram_dout_i;
      end
    end
  end

endmodule : sram_port0_arbiter

// File: tb/tb_sram_port0_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port0_arbiter
//   Bench for sram_port0_arbiter with a behavioural 1rw SRAM port model
//   (command latched at posedge, array access at the following negedge).
//   Expected responses come from a reference memory and a queue of
//   {valid, id, data} entries, one pushed per driven cycle.
// -----------------------------------------------------------------------------
module tb_sram_port0_arbiter;

  localparam int DEPTH = 256;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_we    = '0;
  logic [7:0]  req_be    = '0;
  logic [15:0] req_addr  = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        init_done;
  logic        sram_csb;
  logic        sram_web;
  logic [3:0]  sram_wmask;
  logic [7:0]  sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout = '0;

  sram_port0_arbiter dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_be_i     (req_be),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .init_done_o  (init_done),
    .sram_csb_o   (sram_csb),
    .sram_web_o   (sram_web),
    .sram_wmask_o (sram_wmask),
    .sram_addr_o  (sram_addr),
    .sram_din_o   (sram_din),
    .sram_dout_i  (sram_dout)
  );

  // ---------------------------------------------------------------------------
  // SRAM macro model (port 0): capture at posedge, access at negedge.
  // Array starts with random contents so the zero-fill is observable.
  // ---------------------------------------------------------------------------
  logic [31:0] mem [DEPTH];
  bit          seeded = 1'b0;
  logic        m_csb = 1'b1, m_web = 1'b1;
  logic [3:0]  m_wmask = '0;
  logic [7:0]  m_addr = '0;
  logic [31:0] m_din = '0;

  always @(posedge clk) begin
    m_csb   <= sram_csb;
    m_web   <= sram_web;
    m_wmask <= sram_wmask;
    m_addr  <= sram_addr;
    m_din   <= sram_din;
  end

  always @(negedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();
      seeded = 1'b1;
    end
    if (!m_csb) begin
      if (!m_web) begin
        for (int b = 0; b < 4; b++)
          if (m_wmask[b]) mem[m_addr][8*b +: 8] = m_din[8*b +: 8];
      end else begin
        sram_dout <= mem[m_addr];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [33:0] exp_q[$];          // {valid, id, data}
  logic [31:0] ref_mem [DEPTH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One RUN cycle with the inputs already driven. Checks the response owed
  // from the previous cycle, the grant, and the macro drive; then records the
  // response expected next cycle.
  task automatic step(input logic [1:0] g);
    logic [33:0] e;
    logic        id;
    logic        we;
    logic        exp_web;
    logic [7:0]  a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [1:0]  exp_rv;
    @(negedge clk); #1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = '0;
    exp_rv = e[33] ? (e[32] ? 2'b10 : 2'b01) : 2'b00;
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("rsp_rdata", rsp_rdata, e[31:0]);
    chk("req_ready", req_ready, g);
    if (g != 2'b00) begin
      id      = g[1];
      we      = req_we[id];
      exp_web = ~we;
      a       = id ? req_addr[15:8]   : req_addr[7:0];
      be      = id ? req_be[7:4]      : req_be[3:0];
      wd      = id ? req_wdata[63:32] : req_wdata[31:0];
      chk("sram_csb", sram_csb, 1'b0);
      chk("sram_web", sram_web, exp_web);
      chk("sram_addr", sram_addr, a);
      chk("sram_wmask", sram_wmask, we ? be : 4'h0);
      if (we) begin
        chk("sram_din", sram_din, wd);
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
        e = {1'b1, id, 32'h0};
      end else begin
        e = {1'b1, id, ref_mem[a]};
      end
    end else begin
      chk("idle_csb", sram_csb, 1'b1);
      chk("idle_web", sram_web, 1'b1);
      chk("idle_wmask", sram_wmask, 4'h0);
      chk("idle_addr", sram_addr, 8'h00);
      e = '0;
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Called right after reset is released (posedge + 1): the zero-fill must
  // write addresses 0..255 in order with ready held low, then init_done rises.
  task automatic check_init();
    int         bad_ready, bad_drive, bad_rsp, bad_done;
    logic [7:0] ka;
    bad_ready = 0; bad_drive = 0; bad_rsp = 0; bad_done = 0;
    for (int k = 0; k < DEPTH; k++) begin
      ka = 8'(k);
      @(negedge clk); #1;
      if (req_ready !== 2'b00) bad_ready++;
      if (sram_csb !== 1'b0 || sram_web !== 1'b0 || sram_wmask !== 4'hF ||
          sram_addr !== ka || sram_din !== 32'h0) bad_drive++;
      if (rsp_valid !== 2'b00 || rsp_rdata !== 32'h0) bad_rsp++;
      if (init_done !== 1'b0) bad_done++;
    end
    chk("init_ready_low_cycles", 64'(bad_ready), 64'd0);
    chk("init_fill_drive_cycles", 64'(bad_drive), 64'd0);
    chk("init_rsp_quiet_cycles", 64'(bad_rsp), 64'd0);
    chk("init_done_low_cycles", 64'(bad_done), 64'd0);
    @(posedge clk); #1;
    chk("init_done_rise", init_done, 1'b1);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  we;
    logic [7:0]  be;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [1:0]  exp_grant;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] v, input logic [1:0] we,
                              input logic [7:0] be, input logic [15:0] addr,
                              input logic [63:0] wd, input logic [1:0] g);
    vec_t r;
    r.valid = v; r.we = we; r.be = be; r.addr = addr; r.wdata = wd; r.exp_grant = g;
    return r;
  endfunction

  vec_t vecs [21];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // LSU single writes/reads, partial-byte write, zero-mask write
    vecs[0]  = mk(2'b01, 2'b01, 8'h0F, 16'h0010, 64'h00000000_DEADBEEF, 2'b01);
    vecs[1]  = mk(2'b01, 2'b00, 8'h00, 16'h0010, 64'h0,                 2'b01);
    vecs[2]  = mk(2'b10, 2'b10, 8'hF0, 16'h2000, 64'h11223344_00000000, 2'b10);
    vecs[3]  = mk(2'b10, 2'b10, 8'h20, 16'h2000, 64'h0000AB00_00000000, 2'b10);
    vecs[4]  = mk(2'b10, 2'b00, 8'h00, 16'h2000, 64'h0,                 2'b10);
    vecs[5]  = mk(2'b01, 2'b01, 8'h00, 16'h0020, 64'h00000000_FFFFFFFF, 2'b01);
    vecs[6]  = mk(2'b01, 2'b00, 8'h00, 16'h0020, 64'h0,                 2'b01);
    vecs[7]  = mk(2'b00, 2'b00, 8'h00, 16'h0000, 64'h0,                 2'b00);
    // debug writes then back-to-back reads @1,@2,@3
    vecs[8]  = mk(2'b10, 2'b10, 8'hF0, 16'h0100, 64'h000000A1_00000000, 2'b10);
    vecs[9]  = mk(2'b10, 2'b10, 8'hF0, 16'h0200, 64'h000000A2_00000000, 2'b10);
    vecs[10] = mk(2'b10, 2'b10, 8'hF0, 16'h0300, 64'h000000A3_00000000, 2'b10);
    vecs[11] = mk(2'b10, 2'b00, 8'h00, 16'h0100, 64'h0,                 2'b10);
    vecs[12] = mk(2'b10, 2'b00, 8'h00, 16'h0200, 64'h0,                 2'b10);
    vecs[13] = mk(2'b10, 2'b00, 8'h00, 16'h0300, 64'h0,                 2'b10);
    // contention: last winner was req 1, so grants go 0,1,0,1
    vecs[14] = mk(2'b11, 2'b00, 8'h00, 16'h2010, 64'h0,                 2'b01);
    vecs[15] = mk(2'b11, 2'b00, 8'h00, 16'h2010, 64'h0,                 2'b10);
    vecs[16] = mk(2'b11, 2'b00, 8'h00, 16'h2010, 64'h0,                 2'b01);
    vecs[17] = mk(2'b11, 2'b00, 8'h00, 16'h2010, 64'h0,                 2'b10);
    // contending writes to one address; req 1 must hold valid and land last
    vecs[18] = mk(2'b11, 2'b11, 8'hFF, 16'h3030, 64'h00000066_00000055, 2'b01);
    vecs[19] = mk(2'b10, 2'b10, 8'hF0, 16'h3030, 64'h00000066_00000000, 2'b10);
    vecs[20] = mk(2'b01, 2'b00, 8'h00, 16'h0030, 64'h0,                 2'b01);

    // ---- reset: LSU already requesting a read of 0xFF ----
    req_valid = 2'b01; req_we = 2'b00; req_addr = 16'h00FF;
    #3;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_csb", sram_csb, 1'b1);
    chk("rst_web", sram_web, 1'b1);
    chk("rst_wmask", sram_wmask, 4'h0);
    chk("rst_addr", sram_addr, 8'h00);
    chk("rst_din", sram_din, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // ---- zero-fill, then the held read of 0xFF is accepted first ----
    check_init();
    step(2'b01);

    // ---- table ----
    for (int i = 0; i < 21; i++) begin
      req_valid = vecs[i].valid;
      req_we    = vecs[i].we;
      req_be    = vecs[i].be;
      req_addr  = vecs[i].addr;
      req_wdata = vecs[i].wdata;
      step(vecs[i].exp_grant);
    end
    req_valid = 2'b00; req_we = 2'b00; req_be = '0; req_addr = '0; req_wdata = '0;
    step(2'b00);

    // ---- reset with a read in flight ----
    req_valid = 2'b10; req_addr = 16'h1000; req_we = 2'b00;
    step(2'b10);
    chk("inflight_rsp_before_reset", rsp_valid, 2'b10);
    rst_n = 1'b0;
    req_valid = 2'b00;
    exp_q.delete();
    #1;
    chk("midrst_rsp_valid", rsp_valid, 2'b00);
    chk("midrst_rsp_rdata", rsp_rdata, 32'h0);
    chk("midrst_csb", sram_csb, 1'b1);
    chk("midrst_init_done", init_done, 1'b0);
    @(negedge clk); #1;
    chk("midrst_rsp_valid_later", rsp_valid, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_init();

    // array was re-zeroed, including the word written earlier at 0x10
    req_valid = 2'b01; req_addr = 16'h0010; req_we = 2'b00;
    step(2'b01);
    req_valid = 2'b00;
    step(2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sram_port0_arbiter
